// File: rtl/mc_mem_responder.sv
// mc_mem_responder
//   Unified instruction/data memory responder for the multicycle datapath's
//   memory port. Accepts one request at a time, inserts WAIT_CYCLES wait
//   states, then commits a write or returns read data. Misaligned or
//   out-of-range accesses are flagged with Err and have no side effect on
//   memory.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, < 2**30)
//   WAIT_CYCLES  wait states between accept and access (0..15)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        access request, sampled only while idle
//   MemWrite   1 = write, 0 = read (latched with req)
//   Adr        byte address (latched with req)
//   WriteData  write data (latched with req)
//   ReadData   read result, valid while Ready=1 and held afterwards
//   Ready      one-cycle pulse when the access completes
//   Busy       high while a request is outstanding
//   Err        pulses with Ready when the access was misaligned/out of range
module mc_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_next;

  logic          r_we;
  logic [31:0]   r_adr;
  logic [31:0]   r_wd;

  logic [31:0]   r_rdata;
  logic          r_ready;
  logic          r_err;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_access;
  logic          w_from_port;
  logic          w_acc_we;
  logic [31:0]   w_acc_adr;
  logic [31:0]   w_acc_wd;
  logic          w_valid;
  logic [AW-1:0] w_idx;

  // Next-state logic. w_access marks the edge on which the memory is
  // touched: the edge that moves the FSM into RESP.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_access   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            w_next   = S_RESP;
            w_access = 1'b1;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next   = S_RESP;
          w_access = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge itself, so
  // the operands come straight from the ports instead of the latches.
  always_comb begin
    w_from_port = (r_state == S_IDLE);
    w_acc_we    = w_from_port ? MemWrite  : r_we;
    w_acc_adr   = w_from_port ? Adr       : r_adr;
    w_acc_wd    = w_from_port ? WriteData : r_wd;
    w_valid     = (w_acc_adr[1:0] == 2'b00) && (w_acc_adr[31:AW+2] == '0);
    w_idx       = w_acc_adr[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we  <= 1'b0;
      r_adr <= '0;
      r_wd  <= '0;
    end else if (r_state == S_IDLE && req) begin
      r_we  <= MemWrite;
      r_adr <= Adr;
      r_wd  <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_access;
      r_err   <= w_access && !w_valid;
      if (w_access && !w_acc_we) begin
        r_rdata <= w_valid ? r_mem[w_idx] : '0;
      end
    end
  end

  // Backing array is never cleared; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!reset && w_access && w_valid && w_acc_we) begin
      r_mem[w_idx] <= w_acc_wd;
    end
  end

  assign ReadData = r_rdata;
  assign Ready    = r_ready;
  assign Err      = r_err;
  assign Busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mc_mem_responder.sv
module tb_mc_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: WAIT_CYCLES=1
  logic        a_req, a_we, a_rdy, a_busy, a_err;
  logic [31:0] a_adr, a_wd, a_rd;
  // Instance B: WAIT_CYCLES=0
  logic        b_req, b_we, b_rdy, b_busy, b_err;
  logic [31:0] b_adr, b_wd, b_rd;
  // Instance C: WAIT_CYCLES=2
  logic        c_req, c_we, c_rdy, c_busy, c_err;
  logic [31:0] c_adr, c_wd, c_rd;

  mc_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_a (
    .clk(clk), .reset(rst), .req(a_req), .MemWrite(a_we), .Adr(a_adr),
    .WriteData(a_wd), .ReadData(a_rd), .Ready(a_rdy), .Busy(a_busy), .Err(a_err));

  mc_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .reset(rst), .req(b_req), .MemWrite(b_we), .Adr(b_adr),
    .WriteData(b_wd), .ReadData(b_rd), .Ready(b_rdy), .Busy(b_busy), .Err(b_err));

  mc_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_c (
    .clk(clk), .reset(rst), .req(c_req), .MemWrite(c_we), .Adr(c_adr),
    .WriteData(c_wd), .ReadData(c_rd), .Ready(c_rdy), .Busy(c_busy), .Err(c_err));

  // Drivers: present a request for one cycle; return at the negedge after the accept edge.
  task automatic drive_a(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    @(negedge clk); a_req = 1'b1; a_we = we; a_adr = adr; a_wd = wd;
    @(negedge clk); a_req = 1'b0;
  endtask

  task automatic drive_b(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    @(negedge clk); b_req = 1'b1; b_we = we; b_adr = adr; b_wd = wd;
    @(negedge clk); b_req = 1'b0;
  endtask

  task automatic drive_c(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    @(negedge clk); c_req = 1'b1; c_we = we; c_adr = adr; c_wd = wd;
    @(negedge clk); c_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_adr = 32'h10; a_wd = 32'h1;
    b_req = 1'b0; b_we = 1'b0; b_adr = '0; b_wd = '0;
    c_req = 1'b0; c_we = 1'b0; c_adr = '0; c_wd = '0;
    repeat (2) @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", a_busy); end
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", a_rdy); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", a_err); end
    checks++; if (a_rd !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", a_rd); end
    checks++; if (b_busy !== 1'b0 || c_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_bc got %0b%0b exp 00", b_busy, c_busy); end
    rst = 1'b0; a_req = 1'b0;
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_req_dropped got %0b exp 0", a_busy); end
  endtask

  task automatic test_write_read;
    drive_a(1'b1, 32'h10, 32'hDEADBEEF);
    checks++; if (a_busy !== 1'b1 || a_rdy !== 1'b0) begin errors++; $display("FAIL wr_wait busy/rdy got %0b%0b exp 10", a_busy, a_rdy); end
    @(negedge clk);
    checks++; if (a_rdy !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL wr_resp rdy/err got %0b%0b exp 10", a_rdy, a_err); end
    checks++; if (a_rd !== 32'h0) begin errors++; $display("FAIL wr_rdata_held got %h exp 0", a_rd); end
    @(negedge clk);
    checks++; if (a_rdy !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL wr_done rdy/busy got %0b%0b exp 00", a_rdy, a_busy); end
    drive_a(1'b0, 32'h10, 32'h0);
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL rd_early_ready got %0b exp 0", a_rdy); end
    @(negedge clk);
    checks++; if (a_rdy !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL rd_resp rdy/err got %0b%0b exp 10", a_rdy, a_err); end
    checks++; if (a_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", a_rd); end
  endtask

  task automatic test_wait0;
    drive_b(1'b1, 32'h0, 32'h20080005);
    checks++; if (b_rdy !== 1'b1 || b_busy !== 1'b1) begin errors++; $display("FAIL w0_wr rdy/busy got %0b%0b exp 11", b_rdy, b_busy); end
    drive_b(1'b0, 32'h0, 32'h0);
    checks++; if (b_rdy !== 1'b1 || b_err !== 1'b0) begin errors++; $display("FAIL w0_rd rdy/err got %0b%0b exp 10", b_rdy, b_err); end
    checks++; if (b_rd !== 32'h20080005) begin errors++; $display("FAIL w0_rd_data got %h exp 20080005", b_rd); end
    @(negedge clk);
    checks++; if (b_busy !== 1'b0 || b_rdy !== 1'b0) begin errors++; $display("FAIL w0_busy_len busy/rdy got %0b%0b exp 00", b_busy, b_rdy); end
  endtask

  task automatic test_misaligned;
    drive_a(1'b1, 32'h12, 32'h1234);
    @(negedge clk);
    checks++; if (a_rdy !== 1'b1 || a_err !== 1'b1) begin errors++; $display("FAIL mis_wr rdy/err got %0b%0b exp 11", a_rdy, a_err); end
    checks++; if (a_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_wr_rdata got %h exp deadbeef", a_rd); end
    drive_a(1'b0, 32'h10, 32'h0);
    @(negedge clk);
    checks++; if (a_rd !== 32'hDEADBEEF || a_err !== 1'b0) begin errors++; $display("FAIL mis_word_kept got %h/%0b exp deadbeef/0", a_rd, a_err); end
    drive_a(1'b0, 32'h12, 32'h0);
    @(negedge clk);
    checks++; if (a_rd !== 32'h0 || a_err !== 1'b1 || a_rdy !== 1'b1) begin errors++; $display("FAIL mis_rd got %h/%0b/%0b exp 0/1/1", a_rd, a_err, a_rdy); end
    @(negedge clk);
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL mis_err_pulse got %0b exp 0", a_err); end
  endtask

  task automatic test_out_of_range;
    drive_a(1'b1, 32'h0, 32'h11111111);
    @(negedge clk);
    drive_a(1'b1, 32'h400, 32'hCAFEF00D);
    @(negedge clk);
    checks++; if (a_rdy !== 1'b1 || a_err !== 1'b1) begin errors++; $display("FAIL oor_wr rdy/err got %0b%0b exp 11", a_rdy, a_err); end
    drive_a(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (a_rd !== 32'h11111111 || a_err !== 1'b0) begin errors++; $display("FAIL oor_no_alias got %h/%0b exp 11111111/0", a_rd, a_err); end
    drive_a(1'b0, 32'h400, 32'h0);
    @(negedge clk);
    checks++; if (a_rd !== 32'h0 || a_err !== 1'b1) begin errors++; $display("FAIL oor_rd got %h/%0b exp 0/1", a_rd, a_err); end
    drive_a(1'b0, 32'h80000010, 32'h0);
    @(negedge clk);
    checks++; if (a_rd !== 32'h0 || a_err !== 1'b1) begin errors++; $display("FAIL oor_top_bit got %h/%0b exp 0/1", a_rd, a_err); end
    drive_a(1'b1, 32'h3FC, 32'h55AA55AA);
    @(negedge clk);
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL last_word_wr_err got %0b exp 0", a_err); end
    drive_a(1'b0, 32'h3FC, 32'h0);
    @(negedge clk);
    checks++; if (a_rd !== 32'h55AA55AA || a_err !== 1'b0) begin errors++; $display("FAIL last_word_rd got %h/%0b exp 55aa55aa/0", a_rd, a_err); end
  endtask

  task automatic test_req_held;
    drive_c(1'b1, 32'h4, 32'h00001111);
    repeat (3) @(negedge clk);
    drive_c(1'b1, 32'h8, 32'h00002222);
    repeat (3) @(negedge clk);
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_adr = 32'h4;
    @(negedge clk);                               // after E0: accepted
    checks++; if (c_busy !== 1'b1 || c_rdy !== 1'b0) begin errors++; $display("FAIL held_acc0 busy/rdy got %0b%0b exp 10", c_busy, c_rdy); end
    c_adr = 32'h8;                                // change during WAIT
    @(negedge clk);                               // after E1
    checks++; if (c_rdy !== 1'b0) begin errors++; $display("FAIL held_wait_rdy got %0b exp 0", c_rdy); end
    @(negedge clk);                               // after E2
    checks++; if (c_rdy !== 1'b1 || c_rd !== 32'h00001111) begin errors++; $display("FAIL held_resp0 got %0b/%h exp 1/00001111", c_rdy, c_rd); end
    @(negedge clk);                               // after E3: idle, req ignored in RESP
    checks++; if (c_rdy !== 1'b0 || c_busy !== 1'b0) begin errors++; $display("FAIL held_gap rdy/busy got %0b%0b exp 00", c_rdy, c_busy); end
    @(negedge clk);                               // after E4: second accept
    checks++; if (c_busy !== 1'b1) begin errors++; $display("FAIL held_acc1 busy got %0b exp 1", c_busy); end
    repeat (2) @(negedge clk);                    // after E6
    checks++; if (c_rdy !== 1'b1 || c_rd !== 32'h00002222) begin errors++; $display("FAIL held_resp1 got %0b/%h exp 1/00002222", c_rdy, c_rd); end
    c_req = 1'b0;
    @(negedge clk);
    checks++; if (c_rdy !== 1'b0 || c_busy !== 1'b0) begin errors++; $display("FAIL held_end rdy/busy got %0b%0b exp 00", c_rdy, c_busy); end
  endtask

  task automatic test_reset_in_wait;
    drive_a(1'b1, 32'h20, 32'h0BADF00D);
    @(negedge clk);
    drive_a(1'b1, 32'h20, 32'hFFFFFFFF);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_rdy !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0 || a_rd !== 32'h0) begin
      errors++; $display("FAIL rst_wait outs got %0b%0b%0b/%h exp 000/0", a_rdy, a_busy, a_err, a_rd); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL rst_wait_no_ready got %0b exp 0", a_rdy); end
    drive_a(1'b0, 32'h20, 32'h0);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rst_wait_reaccept got %0b exp 1", a_busy); end
    @(negedge clk);
    checks++; if (a_rdy !== 1'b1 || a_rd !== 32'h0BADF00D) begin errors++; $display("FAIL rst_wait_mem got %0b/%h exp 1/0badf00d", a_rdy, a_rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_wait0();
    test_misaligned();
    test_out_of_range();
    test_req_held();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
